seq_detect_ctrl: RTL and testbench
==================================

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 SHALL have parameter RUN_LEN, default 3: number of consecutive 1 samples that forms one detection; legal range 2..15.
REQ-002 SHALL have parameter WIN_W, default 8: width of the observation-window length and position fields.
REQ-003 SHALL have parameter CNT_W, default 4: width of the hit counter.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1: request one observation window; sampled only in IDLE.
REQ-007 SHALL have port window  input  WIN_W: number of samples to observe; latched when start is accepted.
REQ-008 SHALL have port in  input  1: serial bit stream under observation.
REQ-009 SHALL have port busy  output  1: high in ARM and RUN.
REQ-010 SHALL have port done  output  1: one-cycle pulse when a window completes.
REQ-011 SHALL have port detected  output  1: high while the current run length is at least RUN_LEN.
REQ-012 SHALL have port hit_count  output  CNT_W: detections in the current or last window.
REQ-013 SHALL have port first_hit_pos  output  WIN_W: sample index of the first detection; all-ones if none.

Function
REQ-014 SHALL implement states IDLE, ARM, RUN and DONE, with all outputs registered.
REQ-015 IDLE SHALL move to ARM when start=1, latching window; start SHALL be ignored in every other state.
REQ-016 ARM SHALL last exactly one cycle, clearing the run counter, the sample index, hit_count and detected, and setting first_hit_pos to all-ones.
REQ-017 ARM SHALL move to DONE when the latched window=0, and to RUN otherwise.
REQ-018 RUN SHALL sample in once per cycle, starting the cycle after ARM, with sample index 0..window-1.
REQ-019 in=1 SHALL increment the run counter, saturating at RUN_LEN; in=0 SHALL clear it.
REQ-020 A detection SHALL occur only on the sample where the run length becomes exactly RUN_LEN; longer runs SHALL NOT retrigger; a new detection requires an intervening 0.
REQ-021 On a detection, hit_count SHALL increment, saturating at 2^CNT_W-1.
REQ-022 On the first detection of a window, first_hit_pos SHALL capture the sample index.
REQ-023 detected SHALL be 1 in the cycle after any RUN sample that leaves the run counter at RUN_LEN, and 0 otherwise.
REQ-024 RUN SHALL move to DONE after sample index window-1 is taken.
REQ-025 DONE SHALL assert done for one cycle, clear detected, return to IDLE, and not sample in.
REQ-026 hit_count and first_hit_pos SHALL hold their values in DONE and IDLE until the next ARM.
REQ-027 Latency: start accepted at edge k; ARM in cycle k+1; first sample at edge k+2; done high in cycle k+2+window.

Reset
REQ-028 Reset SHALL asynchronously force IDLE and clear the run counter and sample index.
REQ-029 Reset SHALL force busy=0, done=0, detected=0, hit_count=0, first_hit_pos=all-ones.
REQ-030 Reset asserted mid-window SHALL abandon the window with no done pulse; operation SHALL resume on the first edge after deassertion.

Configuration
REQ-031 When SEQ_CTRL_ABORT_EN is defined, the block SHALL add input port abort (1 bit).
REQ-032 With SEQ_CTRL_ABORT_EN, abort=1 in ARM or RUN SHALL go to IDLE at the next edge with no done pulse, clear detected, and hold hit_count and first_hit_pos.
REQ-033 With SEQ_CTRL_ABORT_EN, abort SHALL take priority over the window-end transition, and SHALL have no effect in IDLE or DONE.
REQ-034 Without SEQ_CTRL_ABORT_EN, the abort port SHALL NOT exist and windows SHALL always run to completion.

Verification
REQ-035 RUN_LEN=3, window=8, in=0,1,1,1,0,1,1,1 -> hit_count=2, first_hit_pos=3, done 10 cycles after start.
REQ-036 window=6, in=1 for all 6 samples -> hit_count=1, first_hit_pos=2, detected high for samples 2..5.
REQ-037 window=0, start=1 -> ARM then DONE, done pulse in cycle k+2, hit_count=0, first_hit_pos=all-ones.
REQ-038 CNT_W=2, window=40, pattern 1,1,1,0 repeated -> hit_count saturates at 3.
REQ-039 start pulsed in RUN, then reset asserted at sample 4 -> second start ignored; outputs at reset values immediately; no done pulse.
REQ-040 SEQ_CTRL_ABORT_EN defined, abort at sample 5 of an 8-sample window with one hit at 2 -> IDLE, no done, hit_count=1, first_hit_pos=2.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: counts runs of RUN_LEN consecutive 1s on a serial bit stream over a start-triggered window.
// Latency: start taken at edge k -> ARM for one cycle -> samples 0..window-1 -> done pulse in cycle k+2+window.
// Backpressure: none; start is only sampled in IDLE and is ignored while a window is in flight.
//
// Ports:
//   clk, reset          - single clock, asynchronous active-high reset
//   start, window       - request a window of `window` samples (window latched on acceptance)
//   in                  - serial bit stream, sampled once per cycle while in RUN
//   busy                - high in ARM and RUN
//   done                - one-cycle pulse when a window completes
//   detected            - high while the current run length is at least RUN_LEN
//   hit_count           - detections in the current/last window (saturating)
//   first_hit_pos       - sample index of the first detection, all-ones if none
//   abort               - only when SEQ_CTRL_ABORT_EN is defined: drop the window, no done pulse
//
// Optional feature macro: SEQ_CTRL_ABORT_EN
module seq_detect_ctrl #(
  parameter int RUN_LEN = 3,
  parameter int WIN_W   = 8,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIN_W-1:0] window,
  input  logic             in,
`ifdef SEQ_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             detected,
  output logic [CNT_W-1:0] hit_count,
  output logic [WIN_W-1:0] first_hit_pos
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // RUN_LEN is at most 15, so four bits always hold the saturating run length.
  localparam logic [3:0] RL    = 4'(RUN_LEN);
  localparam logic [3:0] RL_M1 = 4'(RUN_LEN - 1);

  logic [1:0]       state;
  logic [3:0]       run_cnt;
  logic [WIN_W-1:0] idx;
  logic [WIN_W-1:0] win_q;

  logic             abort_req;
  logic [3:0]       run_nxt;
  logic             hit;
  logic             last;

`ifdef SEQ_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Run length after this cycle's sample; it saturates so long runs cannot retrigger.
  always_comb begin
    run_nxt = 4'd0;
    if (in) begin
      run_nxt = (run_cnt == RL) ? RL : run_cnt + 4'd1;
    end
  end

  // A hit is the single sample on which the run reaches RUN_LEN from below.
  assign hit  = in && (run_cnt == RL_M1);
  // Only evaluated in RUN, where win_q is known to be non-zero.
  assign last = (idx == win_q - 1'b1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      run_cnt       <= 4'd0;
      idx           <= '0;
      win_q         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      detected      <= 1'b0;
      hit_count     <= '0;
      first_hit_pos <= '1;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            win_q <= window;
            busy  <= 1'b1;
            state <= S_ARM;
          end
        end

        S_ARM: begin
          if (abort_req) begin
            busy     <= 1'b0;
            detected <= 1'b0;
            state    <= S_IDLE;
          end else begin
            run_cnt       <= 4'd0;
            idx           <= '0;
            hit_count     <= '0;
            detected      <= 1'b0;
            first_hit_pos <= '1;
            if (win_q == '0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          // Abort wins over the window-end transition and freezes the results.
          if (abort_req) begin
            busy     <= 1'b0;
            detected <= 1'b0;
            state    <= S_IDLE;
          end else begin
            run_cnt  <= run_nxt;
            idx      <= idx + 1'b1;
            detected <= (run_nxt == RL);
            if (hit) begin
              if (hit_count != '1) begin
                hit_count <= hit_count + 1'b1;
              end
              // All-ones marks "no hit yet"; a valid index never reaches it.
              if (first_hit_pos == '1) begin
                first_hit_pos <= idx;
              end
            end
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          detected <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          busy     <= 1'b0;
          detected <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;
  localparam int RUN_LEN = 3;
  localparam int WIN_W   = 8;
  localparam int CNT_W   = 2;
  localparam int HIST    = 16384;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIN_W-1:0] window;
  logic             in;
`ifdef SEQ_CTRL_ABORT_EN
  logic             abort;
`endif
  logic             busy;
  logic             done;
  logic             detected;
  logic [CNT_W-1:0] hit_count;
  logic [WIN_W-1:0] first_hit_pos;

  seq_detect_ctrl #(.RUN_LEN(RUN_LEN), .WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .window(window),
    .in(in),
`ifdef SEQ_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy),
    .done(done),
    .detected(detected),
    .hit_count(hit_count),
    .first_hit_pos(first_hit_pos)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; stable in the period after each edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int win_cnt = 0;

  typedef struct {
    int k;
    int w;
    int hits;
    int fhp;
    logic [255:0] det;
  } exp_t;

  exp_t sb[$];
  logic det_hist [HIST];
  logic busy_hist[HIST];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a sample is "in a run" when it and the RUN_LEN-1 samples
  // before it in the window are all 1; a detection is such a sample whose
  // predecessor run start is preceded by a 0 (or by the window start).
  function automatic exp_t model(input logic [255:0] b, input int w, input int k);
    exp_t e;
    bit   full;
    e.k = k; e.w = w; e.hits = 0; e.fhp = (1 << WIN_W) - 1; e.det = '0;
    for (int i = 0; i < w; i++) begin
      full = (i >= RUN_LEN - 1);
      if (full) begin
        for (int j = 0; j < RUN_LEN; j++) if (!b[i-j]) full = 0;
      end
      e.det[i] = full;
      if (full) begin
        if (i == RUN_LEN - 1 || !b[i-RUN_LEN]) begin
          if (e.hits < (1 << CNT_W) - 1) e.hits++;
          if (e.fhp == (1 << WIN_W) - 1) e.fhp = i;
        end
      end
    end
    return e;
  endfunction

  // Monitor: records per-cycle outputs and checks each completed window.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    int   md, mb;
    logic ed, eb;
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (cyc < HIST) begin
        det_hist[cyc]  = detected;
        busy_hist[cyc] = busy;
      end
      if (prev_done) chk("det_after_done", int'(detected), 0);
      if (done) begin
        done_cnt++;
        chk("done_width", int'(prev_done), 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", int'(done), 0);
        end else begin
          e = sb.pop_front();
          chk("done_latency", cyc, e.k + 1 + e.w);
          chk("hit_count", int'(hit_count), e.hits);
          chk("first_hit_pos", int'(first_hit_pos), e.fhp);
          md = 0; mb = 0;
          for (int c = e.k; c <= e.k + 1 + e.w; c++) begin
            ed = (c >= e.k + 2) ? e.det[c-e.k-2] : 1'b0;
            eb = (c <= e.k + e.w);
            if (c < HIST) begin
              if (det_hist[c] !== ed) md++;
              if (busy_hist[c] !== eb) mb++;
            end
          end
          chk("det_trace_mismatches", md, 0);
          chk("busy_trace_mismatches", mb, 0);
        end
      end
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one full window; noisy=1 also toggles start while the window runs.
  task automatic run_window(input int w, input logic [255:0] bits, input bit noisy);
    int   k;
    exp_t e;
    tick();
    start = 1'b1;
    window = WIN_W'(w);
    tick();
    k = cyc;
    e = model(bits, w, k);
    sb.push_back(e);
    win_cnt++;
    start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    window = WIN_W'($urandom);
    in = 1'($urandom);
    tick();
    for (int i = 0; i < w; i++) begin
      in = bits[i];
      if (noisy) start = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    in = 1'($urandom);
    tick();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  function automatic logic [255:0] rand_bits();
    logic [255:0] b;
    for (int i = 0; i < 256; i++) b[i] = ($urandom_range(0, 9) < 7);
    return b;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_detected"}, int'(detected), 0);
    chk({tag, "_hit_count"}, int'(hit_count), 0);
    chk({tag, "_first_hit_pos"}, int'(first_hit_pos), (1 << WIN_W) - 1);
  endtask

  initial begin
    logic [255:0] b;
    int t;
    reset = 1'b0; start = 1'b0; window = '0; in = 1'b0;
`ifdef SEQ_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    #2 reset = 1'b1;
    #1 check_reset_vals("reset_init");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Two separated runs of three.
    b = '0; b[7:0] = 8'b1110_1110;
    run_window(8, b, 1'b0);
    // One long run: single hit at index 2, detected for samples 2..5.
    b = '0; b[5:0] = 6'b111111;
    run_window(6, b, 1'b0);
    // Empty window.
    b = '0;
    run_window(0, b, 1'b0);
    // Ten hits saturate a 2-bit counter.
    b = '0;
    for (int i = 0; i < 40; i++) b[i] = (i % 4 != 3);
    run_window(40, b, 1'b0);

    for (int n = 0; n < 40; n++) run_window($urandom_range(0, 50), rand_bits(), 1'b1);
    run_window(255, rand_bits(), 1'b1);

    // Reset mid-window after a stray start in RUN: abandoned, no done pulse.
    tick();
    start = 1'b1; window = 8'd10; in = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1 check_reset_vals("reset_mid");
    tick();
    tick();
    reset = 1'b0;
    in = 1'b0;
    tick();
    run_window(12, rand_bits(), 1'b0);

`ifdef SEQ_CTRL_ABORT_EN
    // Abort while sample 5 is pending: back to IDLE, results frozen.
    tick();
    start = 1'b1; window = 8'd8; in = 1'b1;
    tick();
    start = 1'b0;
    tick();
    b = '0; b[2:0] = 3'b111;
    for (int i = 0; i < 5; i++) begin
      in = b[i];
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_hit_count", int'(hit_count), 1);
    chk("abort_first_hit_pos", int'(first_hit_pos), 2);
    repeat (12) tick();
    run_window(5, rand_bits(), 1'b0);
`endif

    t = 0;
    while (sb.size() != 0 && t < 300) begin
      tick();
      t++;
    end
    repeat (3) tick();
    chk("scoreboard_empty", sb.size(), 0);
    chk("done_pulses", done_cnt, win_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
